// File: rtl/vga_pkg.sv
// Shared definitions for the VGA line-fetch path.
// Holds the fetch FSM state encodings.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/vline_fetch.sv
// Fetches one video line, one pixel per memory word,
// into a small line buffer.
module vline_fetch #(
    parameter int AWIDTH  = 2,
    parameter int BPP     = 6,
    parameter int PSIZE   = 4,
    parameter int MAWIDTH = 12
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               LineStart,
    input  logic [MAWIDTH-1:0] LineIndex,
    output logic               MemReq,
    output logic [MAWIDTH-1:0] MemAddress,
    input  logic               MemAck,
    input  logic [BPP-1:0]     MemData,
    output logic               Write,
    output logic [AWIDTH-1:0]  WriteAddress,
    output logic [BPP-1:0]     DataIn,
    output logic               Busy,
    output logic               Overrun
);
    import vga_pkg::*;

    localparam logic [MAWIDTH-1:0] PSIZE_M = MAWIDTH'(PSIZE);
    localparam logic [AWIDTH-1:0]  LAST    = AWIDTH'(PSIZE - 1);

    fetch_state_e       state_q;
    logic [MAWIDTH-1:0] base_q;
    logic [AWIDTH-1:0]  count_q;
    logic               mem_req_q;
    logic [MAWIDTH-1:0] mem_addr_q;
    logic               write_q;
    logic [AWIDTH-1:0]  wr_addr_q;
    logic [BPP-1:0]     data_q;
    logic               busy_q;
    logic               overrun_q;

    logic [MAWIDTH-1:0] base_d;
    logic [AWIDTH-1:0]  count_d;
    logic [MAWIDTH-1:0] addr_d;

    assign base_d  = LineIndex * PSIZE_M;
    assign count_d = count_q + AWIDTH'(1);
    assign addr_d  = base_q + MAWIDTH'(count_d);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            write_q    <= 1'b0;
            wr_addr_q  <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            write_q <= 1'b0;
            // A request while busy is dropped but remembered.
            if (LineStart && state_q != ST_IDLE) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (LineStart) begin
                        state_q    <= ST_REQ;
                        base_q     <= base_d;
                        count_q    <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= base_d;
                        busy_q     <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (MemAck) begin
                        state_q   <= ST_WRITE;
                        data_q    <= MemData;
                        mem_req_q <= 1'b0;
                        write_q   <= 1'b1;
                        wr_addr_q <= count_q;
                    end
                end
                ST_WRITE: begin
                    count_q <= count_d;
                    if (count_q != LAST) begin
                        state_q    <= ST_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= addr_d;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign MemReq       = mem_req_q;
    assign MemAddress   = mem_addr_q;
    assign Write        = write_q;
    assign WriteAddress = wr_addr_q;
    assign DataIn       = data_q;
    assign Busy         = busy_q;
    assign Overrun      = overrun_q;

endmodule

// File: tb/tb_vline_fetch.sv
// Bench for vline_fetch: random memory latency, reference
// line model from index arithmetic, and a 4-bit-address copy.
module tb_vline_fetch;

    localparam int AW   = 2;
    localparam int BPP  = 6;
    localparam int PS   = 4;
    localparam int MAW  = 12;
    localparam int MAW4 = 4;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic           LineStart = 1'b0;
    logic [MAW-1:0] LineIndex = '0;
    logic           MemAck = 1'b0;
    logic [BPP-1:0] MemData = '0;

    logic            MemReq, Write, Busy, Overrun;
    logic [MAW-1:0]  MemAddress;
    logic [AW-1:0]   WriteAddress;
    logic [BPP-1:0]  DataIn;
    logic            MemReq4, Write4, Busy4, Overrun4;
    logic [MAW4-1:0] MemAddress4;
    logic [AW-1:0]   WriteAddress4;
    logic [BPP-1:0]  DataIn4;

    vline_fetch #(
        .AWIDTH(AW), .BPP(BPP), .PSIZE(PS), .MAWIDTH(MAW)
    ) u_dut (
        .Clk(Clk), .Reset(Reset), .LineStart(LineStart),
        .LineIndex(LineIndex), .MemReq(MemReq),
        .MemAddress(MemAddress), .MemAck(MemAck),
        .MemData(MemData), .Write(Write),
        .WriteAddress(WriteAddress), .DataIn(DataIn),
        .Busy(Busy), .Overrun(Overrun)
    );

    vline_fetch #(
        .AWIDTH(AW), .BPP(BPP), .PSIZE(PS), .MAWIDTH(MAW4)
    ) u_dut4 (
        .Clk(Clk), .Reset(Reset), .LineStart(LineStart),
        .LineIndex(LineIndex[MAW4-1:0]), .MemReq(MemReq4),
        .MemAddress(MemAddress4), .MemAck(MemAck),
        .MemData(MemData), .Write(Write4),
        .WriteAddress(WriteAddress4), .DataIn(DataIn4),
        .Busy(Busy4), .Overrun(Overrun4)
    );

    always #5 Clk = ~Clk;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int t0 = 0;
    int first_wr = -1;
    int busy_cnt = 0;
    bit ack_tied = 0;
    bit spur_en = 0;
    int wmin = 0;
    int wmax = 0;
    int wcnt = 0;
    bit pending = 0;
    bit hold_prev = 0;
    logic [MAW-1:0] prev_addr = '0;
    logic [BPP-1:0] salt = '0;

    logic [MAW-1:0]  obs_addr[$];
    logic [MAW4-1:0] obs_addr4[$];
    logic [AW-1:0]   obs_wa[$];
    logic [BPP-1:0]  obs_data[$];

    function automatic logic [MAW-1:0] exp_addr(input int idx, input int k, input int maw);
        int a;
        a = (idx * PS + k) % (1 << maw);
        return a[MAW-1:0];
    endfunction

    function automatic logic [BPP-1:0] mem_word(input logic [MAW-1:0] a);
        return a[BPP-1:0] ^ salt;
    endfunction

    task automatic clear_obs();
        obs_addr.delete();
        obs_addr4.delete();
        obs_wa.delete();
        obs_data.delete();
        busy_cnt = 0;
        first_wr = -1;
    endtask

    // One clock: observe outputs, then play the memory for the next edge.
    task automatic step();
        @(negedge Clk);
        cyc++;
        LineStart = 1'b0;
        if (hold_prev && !Reset) begin
            nchk++;
            if (MemReq !== 1'b1 || MemAddress !== prev_addr) begin
                nerr++;
                $display("FAIL req_stable: MemReq=%b MemAddress=%0d required MemReq=1 MemAddress=%0d",
                         MemReq, MemAddress, prev_addr);
            end
        end
        if (Write === 1'b1) begin
            obs_wa.push_back(WriteAddress);
            obs_data.push_back(DataIn);
            if (first_wr < 0) first_wr = cyc;
        end
        if (Busy === 1'b1) busy_cnt++;
        hold_prev = 0;
        if (Reset) pending = 0;
        if (MemReq === 1'b1) begin
            if (!pending) begin
                pending = 1;
                wcnt = ack_tied ? 0 : int'($urandom_range(wmax, wmin));
            end
            if (wcnt == 0) begin
                MemAck = 1'b1;
                MemData = mem_word(MemAddress);
                obs_addr.push_back(MemAddress);
                obs_addr4.push_back(MemAddress4);
                pending = 0;
            end else begin
                wcnt--;
                MemAck = 1'b0;
                MemData = BPP'($urandom);
                hold_prev = 1;
                prev_addr = MemAddress;
            end
        end else begin
            pending = 0;
            MemAck = ack_tied || (spur_en && $urandom_range(1, 0) == 1);
            MemData = BPP'($urandom);
        end
    endtask

    task automatic fetch_line(input logic [MAW-1:0] idx, input bit lead);
        int n;
        clear_obs();
        if (lead) step();
        LineStart = 1'b1;
        LineIndex = idx;
        t0 = cyc;
        n = 0;
        do begin
            step();
            n++;
        end while (Busy === 1'b1 && n < 400);
        nchk++;
        if (n >= 400) begin
            nerr++;
            $display("FAIL fetch_timeout: cycles=%0d required below 400", n);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        nchk++;
        if ({MemReq, Write, Busy, Overrun} !== 4'b0) begin
            nerr++;
            $display("FAIL reset_ctrl: req/wr/busy/ovr=%b required 0000",
                     {MemReq, Write, Busy, Overrun});
        end
        nchk++;
        if (MemAddress !== '0 || WriteAddress !== '0 || DataIn !== '0) begin
            nerr++;
            $display("FAIL reset_data: addr=%0d wa=%0d data=%0d required 0 0 0",
                     MemAddress, WriteAddress, DataIn);
        end
        nchk++;
        if ({MemReq4, Write4, Busy4, Overrun4} !== 4'b0 ||
            MemAddress4 !== '0 || WriteAddress4 !== '0 || DataIn4 !== '0) begin
            nerr++;
            $display("FAIL reset_dut4: ctrl=%b addr=%0d wa=%0d data=%0d required all 0",
                     {MemReq4, Write4, Busy4, Overrun4}, MemAddress4, WriteAddress4, DataIn4);
        end
        Reset = 1'b0;
    endtask

    task automatic test_zero_wait();
        ack_tied = 1;
        spur_en = 0;
        salt = '0;
        fetch_line(12'd3, 1);
        nchk++;
        if (obs_wa.size() != PS) begin
            nerr++;
            $display("FAIL zw_writes: got %0d required %0d", obs_wa.size(), PS);
        end
        for (int k = 0; k < PS; k++) begin
            nchk++;
            if (k >= obs_wa.size() || k >= obs_addr.size() ||
                obs_addr[k] !== MAW'(12 + k) || obs_wa[k] !== AW'(k) ||
                obs_data[k] !== BPP'(12 + k)) begin
                nerr++;
                $display("FAIL zw_pixel%0d: addr=%0d wa=%0d data=%0d required %0d %0d %0d",
                         k, obs_addr[k], obs_wa[k], obs_data[k], 12 + k, k, 12 + k);
            end
        end
        nchk++;
        if (busy_cnt != 2 * PS) begin
            nerr++;
            $display("FAIL zw_busy: got %0d cycles required %0d", busy_cnt, 2 * PS);
        end
        nchk++;
        if (first_wr - t0 != 2) begin
            nerr++;
            $display("FAIL zw_latency: got %0d required 2", first_wr - t0);
        end
    endtask

    task automatic test_wait_states();
        logic [MAW-1:0] idx;
        ack_tied = 0;
        spur_en = 0;
        wmin = 3;
        wmax = 3;
        salt = BPP'($urandom);
        idx = MAW'($urandom);
        fetch_line(idx, 1);
        nchk++;
        if (obs_wa.size() != PS) begin
            nerr++;
            $display("FAIL ws_writes: got %0d required %0d", obs_wa.size(), PS);
        end
        for (int k = 0; k < PS; k++) begin
            nchk++;
            if (k >= obs_wa.size() || k >= obs_addr.size() ||
                obs_addr[k] !== exp_addr(int'(idx), k, MAW) || obs_wa[k] !== AW'(k) ||
                obs_data[k] !== mem_word(exp_addr(int'(idx), k, MAW))) begin
                nerr++;
                $display("FAIL ws_pixel%0d: addr=%0d wa=%0d data=%0d required %0d %0d %0d",
                         k, obs_addr[k], obs_wa[k], obs_data[k],
                         exp_addr(int'(idx), k, MAW), k, mem_word(exp_addr(int'(idx), k, MAW)));
            end
        end
        nchk++;
        if (busy_cnt != 5 * PS) begin
            nerr++;
            $display("FAIL ws_busy: got %0d cycles required %0d", busy_cnt, 5 * PS);
        end
    endtask

    task automatic test_back_to_back();
        logic [MAW-1:0] idx;
        ack_tied = 1;
        spur_en = 0;
        for (int r = 0; r < 3; r++) begin
            salt = BPP'($urandom);
            idx = MAW'($urandom);
            fetch_line(idx, r == 0);
            nchk++;
            if (obs_wa.size() != PS || busy_cnt != 2 * PS || first_wr - t0 != 2) begin
                nerr++;
                $display("FAIL b2b_line%0d: writes=%0d busy=%0d lat=%0d required %0d %0d 2",
                         r, obs_wa.size(), busy_cnt, first_wr - t0, PS, 2 * PS);
            end
            for (int k = 0; k < PS; k++) begin
                nchk++;
                if (k >= obs_addr.size() || k >= obs_wa.size() ||
                    obs_addr[k] !== exp_addr(int'(idx), k, MAW) ||
                    obs_data[k] !== mem_word(exp_addr(int'(idx), k, MAW))) begin
                    nerr++;
                    $display("FAIL b2b_pixel%0d: addr=%0d data=%0d required %0d %0d",
                             k, obs_addr[k], obs_data[k], exp_addr(int'(idx), k, MAW),
                             mem_word(exp_addr(int'(idx), k, MAW)));
                end
            end
        end
        nchk++;
        if (Overrun !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_overrun: got %b required 0", Overrun);
        end
    endtask

    task automatic test_spurious_ack();
        logic [MAW-1:0] idx;
        ack_tied = 0;
        spur_en = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            nchk++;
            if (MemReq !== 1'b0 || Write !== 1'b0 || Busy !== 1'b0) begin
                nerr++;
                $display("FAIL spur_idle%0d: req=%b wr=%b busy=%b required 0 0 0",
                         i, MemReq, Write, Busy);
            end
            MemAck = 1'b1;
            MemData = BPP'($urandom);
        end
        idx = MAW'($urandom);
        salt = BPP'($urandom);
        fetch_line(idx, 1);
        nchk++;
        if (obs_wa.size() != PS || obs_addr.size() == 0 ||
            obs_addr[0] !== exp_addr(int'(idx), 0, MAW) || obs_wa[0] !== AW'(0)) begin
            nerr++;
            $display("FAIL spur_after: writes=%0d addr0=%0d wa0=%0d required %0d %0d 0",
                     obs_wa.size(), obs_addr[0], obs_wa[0], PS, exp_addr(int'(idx), 0, MAW));
        end
    endtask

    task automatic test_wrap();
        int idxs[4] = '{3, 4, 1023, 1024};
        ack_tied = 1;
        spur_en = 0;
        salt = '0;
        for (int r = 0; r < 4; r++) begin
            fetch_line(MAW'(idxs[r]), 1);
            for (int k = 0; k < PS; k++) begin
                nchk++;
                if (k >= obs_addr.size() ||
                    obs_addr[k] !== exp_addr(idxs[r], k, MAW) ||
                    obs_addr4[k] !== MAW4'(exp_addr(idxs[r], k, MAW4))) begin
                    nerr++;
                    $display("FAIL wrap_idx%0d_px%0d: addr=%0d addr4=%0d required %0d %0d",
                             idxs[r], k, obs_addr[k], obs_addr4[k],
                             exp_addr(idxs[r], k, MAW), exp_addr(idxs[r], k, MAW4));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [MAW-1:0] idx;
        ack_tied = 0;
        spur_en = 1;
        wmin = 0;
        wmax = 4;
        for (int r = 0; r < 6; r++) begin
            salt = BPP'($urandom);
            idx = MAW'($urandom);
            fetch_line(idx, 1);
            nchk++;
            if (obs_wa.size() != PS) begin
                nerr++;
                $display("FAIL rnd_writes%0d: got %0d required %0d", r, obs_wa.size(), PS);
            end
            for (int k = 0; k < PS; k++) begin
                nchk++;
                if (k >= obs_wa.size() || k >= obs_addr.size() ||
                    obs_addr[k] !== exp_addr(int'(idx), k, MAW) || obs_wa[k] !== AW'(k) ||
                    obs_data[k] !== mem_word(exp_addr(int'(idx), k, MAW))) begin
                    nerr++;
                    $display("FAIL rnd_line%0d_px%0d: addr=%0d wa=%0d data=%0d required %0d %0d %0d",
                             r, k, obs_addr[k], obs_wa[k], obs_data[k],
                             exp_addr(int'(idx), k, MAW), k, mem_word(exp_addr(int'(idx), k, MAW)));
                end
            end
        end
        spur_en = 0;
    endtask

    task automatic test_overrun();
        int n;
        logic [MAW-1:0] idx, idx2;
        ack_tied = 0;
        spur_en = 0;
        wmin = 0;
        wmax = 2;
        salt = BPP'($urandom);
        idx = MAW'($urandom);
        idx2 = idx ^ 12'h5a5;
        clear_obs();
        step();
        LineStart = 1'b1;
        LineIndex = idx;
        n = 0;
        do begin
            step();
            n++;
        end while (obs_wa.size() < 1 && n < 100);
        step();
        LineStart = 1'b1;
        LineIndex = idx2;
        n = 0;
        do begin
            step();
            n++;
        end while (Busy === 1'b1 && n < 200);
        nchk++;
        if (Overrun !== 1'b1 || obs_wa.size() != PS) begin
            nerr++;
            $display("FAIL ovr_flag: overrun=%b writes=%0d required 1 %0d",
                     Overrun, obs_wa.size(), PS);
        end
        for (int k = 0; k < PS; k++) begin
            nchk++;
            if (k >= obs_addr.size() || k >= obs_wa.size() ||
                obs_addr[k] !== exp_addr(int'(idx), k, MAW) || obs_wa[k] !== AW'(k)) begin
                nerr++;
                $display("FAIL ovr_px%0d: addr=%0d wa=%0d required %0d %0d",
                         k, obs_addr[k], obs_wa[k], exp_addr(int'(idx), k, MAW), k);
            end
        end
        fetch_line(idx2, 1);
        nchk++;
        if (obs_wa.size() != PS || obs_addr.size() == 0 ||
            obs_addr[0] !== exp_addr(int'(idx2), 0, MAW) || Overrun !== 1'b1) begin
            nerr++;
            $display("FAIL ovr_next: writes=%0d addr0=%0d overrun=%b required %0d %0d 1",
                     obs_wa.size(), obs_addr[0], Overrun, PS, exp_addr(int'(idx2), 0, MAW));
        end
    endtask

    task automatic test_final_overrun();
        int n;
        logic [MAW-1:0] idx;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        nchk++;
        if (Overrun !== 1'b0) begin
            nerr++;
            $display("FAIL fo_cleared: overrun=%b required 0", Overrun);
        end
        ack_tied = 1;
        spur_en = 0;
        idx = MAW'($urandom);
        clear_obs();
        step();
        LineStart = 1'b1;
        LineIndex = idx;
        n = 0;
        do begin
            step();
            n++;
        end while (obs_wa.size() < PS && n < 100);
        LineStart = 1'b1;
        LineIndex = idx + 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            nchk++;
            if (Busy !== 1'b0 || MemReq !== 1'b0) begin
                nerr++;
                $display("FAIL fo_idle%0d: busy=%b req=%b required 0 0", i, Busy, MemReq);
            end
        end
        nchk++;
        if (Overrun !== 1'b1 || obs_wa.size() != PS) begin
            nerr++;
            $display("FAIL fo_flag: overrun=%b writes=%0d required 1 %0d",
                     Overrun, obs_wa.size(), PS);
        end
    endtask

    task automatic test_midline_reset();
        int n;
        logic [MAW-1:0] idx;
        ack_tied = 1;
        spur_en = 0;
        idx = MAW'($urandom);
        clear_obs();
        step();
        LineStart = 1'b1;
        LineIndex = idx;
        n = 0;
        do begin
            step();
            n++;
        end while (obs_wa.size() < 3 && n < 100);
        Reset = 1'b1;
        step();
        nchk++;
        if ({MemReq, Write, Busy, Overrun} !== 4'b0 ||
            MemAddress !== '0 || WriteAddress !== '0 || DataIn !== '0) begin
            nerr++;
            $display("FAIL mr_outputs: ctrl=%b addr=%0d wa=%0d data=%0d required all 0",
                     {MemReq, Write, Busy, Overrun}, MemAddress, WriteAddress, DataIn);
        end
        Reset = 1'b0;
        MemAck = 1'b1;
        MemData = BPP'($urandom);
        for (int i = 0; i < 4; i++) begin
            step();
            nchk++;
            if (Busy !== 1'b0 || Write !== 1'b0 || obs_wa.size() != 3) begin
                nerr++;
                $display("FAIL mr_quiet%0d: busy=%b wr=%b writes=%0d required 0 0 3",
                         i, Busy, Write, obs_wa.size());
            end
        end
        salt = BPP'($urandom);
        fetch_line(idx, 0);
        for (int k = 0; k < PS; k++) begin
            nchk++;
            if (k >= obs_wa.size() || k >= obs_addr.size() ||
                obs_wa[k] !== AW'(k) || obs_addr[k] !== exp_addr(int'(idx), k, MAW)) begin
                nerr++;
                $display("FAIL mr_refetch_px%0d: wa=%0d addr=%0d required %0d %0d",
                         k, obs_wa[k], obs_addr[k], k, exp_addr(int'(idx), k, MAW));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_back_to_back();
        test_spurious_ack();
        test_wrap();
        test_random();
        test_overrun();
        test_final_overrun();
        test_midline_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/vline_fetch.md
VLINE_FETCH -- requirements
Module: vline_fetch

Interface
REQ-001 SHALL have parameter AWIDTH, default 2, meaning the line-buffer address width.
REQ-002 SHALL have parameter BPP, default 6, meaning the number of bits per pixel.
REQ-003 SHALL have parameter PSIZE, default 4, meaning the number of pixels fetched per line (at most 2^AWIDTH).
REQ-004 SHALL have parameter MAWIDTH, default 12, meaning the memory word address width.
REQ-005 SHALL have port Clk  input  1  the single clock; all logic is on the rising edge.
REQ-006 SHALL have port Reset  input  1  synchronous active-high reset, sampled on the Clk rising edge.
REQ-007 SHALL have port LineStart  input  1  single-cycle pulse that requests a fetch of one line.
REQ-008 SHALL have port LineIndex  input  MAWIDTH  the line number, sampled when LineStart is accepted.
REQ-009 SHALL have port MemReq  output  1  memory read request.
REQ-010 SHALL have port MemAddress  output  MAWIDTH  memory word address, one pixel per word.
REQ-011 SHALL have port MemAck  input  1  memory acknowledge; MemData is valid in the same cycle.
REQ-012 SHALL have port MemData  input  BPP  memory read data.
REQ-013 SHALL have port Write  output  1  line-buffer write strobe.
REQ-014 SHALL have port WriteAddress  output  AWIDTH  line-buffer pixel index.
REQ-015 SHALL have port DataIn  output  BPP  pixel written to the line buffer.
REQ-016 SHALL have port Busy  output  1  high while a line fetch is in progress.
REQ-017 SHALL have port Overrun  output  1  sticky flag indicating that a LineStart arrived while Busy.

Function
REQ-018 SHALL implement the FSM states IDLE, REQ, WRITE with these transitions:
- IDLE->REQ on LineStart.
- REQ->WRITE on MemAck.
- WRITE->REQ if Count<PSIZE-1, else WRITE->IDLE.
REQ-019 SHALL latch Base = LineIndex*PSIZE, truncated to MAWIDTH bits, and clear Count to 0 on acceptance in IDLE.
REQ-020 SHALL, in REQ, hold MemReq=1 and MemAddress=Base+Count (mod 2^MAWIDTH), stable until MemAck is sampled high.
REQ-021 SHALL capture MemData into DataIn on the MemAck cycle.
REQ-022 SHALL, in WRITE, assert Write=1 for exactly one cycle with WriteAddress=Count, then increment Count.
REQ-023 SHALL drive MemReq=0 in IDLE and WRITE, and Write=0 outside WRITE.
REQ-024 SHALL take minimum 2 cycles per pixel (zero-wait MemAck); the first Write occurs 2 cycles after LineStart is accepted with MemAck already high.
REQ-025 SHALL drive Busy=1 in REQ and WRITE, and Busy=0 in IDLE.
REQ-026 SHALL ignore LineStart while Busy, leaving the current fetch unaffected, and set Overrun=1 until Reset.
REQ-027 SHALL ignore MemAck outside REQ.
REQ-028 SHALL terminate the line after PSIZE writes; the Count wrap is never observed on WriteAddress.
REQ-029 SHALL, when LineStart arrives in the same cycle as the final WRITE, count it as an overrun and not accept it.

Reset
REQ-030 SHALL force state IDLE on Reset=1, with MemReq=0, Write=0, Busy=0, Overrun=0, MemAddress=0, WriteAddress=0, DataIn=0, and Count=0.
REQ-031 SHALL abort a fetch immediately on Reset mid-operation, with no further Write; any MemAck in the following cycle is ignored.

Structure
REQ-032 SHALL place the FSM state encodings in the shared package vga_pkg.
REQ-033 SHALL keep pixel and address widths as module parameters, not package constants.
REQ-034 SHALL be a single module with no sub-module.

Verification
REQ-035 SHALL cover the zero-wait case: LineIndex=3, MemAck tied high, MemData=Address[5:0] -> MemAddress 12,13,14,15; Write at WriteAddress 0..3 with DataIn 12..15; Busy high for 8 cycles.
REQ-036 SHALL cover wait states: MemAck delayed 3 cycles per request -> MemReq and MemAddress stay stable throughout each wait; exactly 4 Writes occur.
REQ-037 SHALL cover overrun: LineStart re-pulsed at pixel 1 -> Overrun=1; the fetch completes unchanged; the next LineStart in IDLE is accepted.
REQ-038 SHALL cover mid-line reset: Reset during WRITE of pixel 2 -> the next cycle is IDLE with all outputs 0; a subsequent fetch starts at WriteAddress 0.
REQ-039 SHALL cover address wrap: MAWIDTH=4, LineIndex=3, PSIZE=4 -> MemAddress 12,13,14,15; with LineIndex=4 -> MemAddress 0..3.
REQ-040 SHALL cover a spurious MemAck in IDLE -> no Write, no state change.
